control_sequencer: RTL and testbench
====================================

Name: control_sequencer

Overview:
- Hardwired Moore control unit that drives every control input of the CPU datapath.
- Steps each instruction through fetch (T0–T2) and execute (T3–T7) cycles.
- Decodes opcode IR[31:27].
- Sits beside the datapath and consumes only IR and the branch condition flip-flop output.

Parameters:
ADD_OP, 5'd3, ALU operation code for address, PC-increment and branch-target adds
STEP_W, 3, width of step counter (T0..T7)

Ports:
clk  input  1  system clock, rising edge
clr  input  1  asynchronous, active-low reset
ir  input  32  IR register contents; opcode = ir[31:27]
con_ff  input  1  branch condition result
stop  input  1  halt request, sampled on last step of an instruction
PCout, ZHighout, ZLowout, HIout, LOout, InPortout, Cout, MDRout  output  1  bus source selects
MARin, PCin, MDRin, IRin, Yin, HIin, LOin, ZHIin, ZLOin, CONin, OutPortin  output  1  register load enables
IncPC, Read, Write  output  1  PC-increment ALU mode, MDR source/memory read, RAM write enable
Gra, Grb, Grc, Rin, Rout, BAout  output  1  register-field select and GPR in/out/base-address controls
operation  output  5  ALU opcode
run  output  1  high while executing, low in HALT

Behaviour:
- One clock. Reset is asynchronous and active-low. While clr=0: state=T0, all control outputs 0, operation=0, run=1.
- Outputs are a pure function of the step register and ir (Moore). Nothing unlisted is asserted in any step.
- Fetch:
  - T0: PCout MARin IncPC ZLOin, operation=ADD_OP.
  - T1: ZLowout PCin Read MDRin.
  - T2: MDRout IRin.
- The IR opcode is valid from T3.
- Execute steps by opcode:
  - R-type (3..11: add sub and or shr shra shl ror rol):
    - T3 Grb Rout Yin.
    - T4 Grc Rout operation=opcode ZLOin.
    - T5 ZLowout Gra Rin.
  - Immediate (12..14: addi andi ori):
    - T3 Grb Rout Yin.
    - T4 Cout operation=opcode ZLOin.
    - T5 ZLowout Gra Rin.
  - ld (0):
    - T3 Grb BAout Yin.
    - T4 Cout ADD ZLOin.
    - T5 ZLowout MARin.
    - T6 Read MDRin.
    - T7 MDRout Gra Rin.
  - ldi (1): T3–T4 as ld, then T5 ZLowout Gra Rin.
  - st (2):
    - T3–T5 as ld.
    - T6 Gra Rout MDRin (Read=0).
    - T7 Write.
  - mul/div (15,16):
    - T3 Gra Rout Yin.
    - T4 Grb Rout operation=opcode ZHIin ZLOin.
    - T5 ZLowout LOin.
    - T6 ZHighout HIin.
  - neg/not (17,18):
    - T3 Grb Rout operation=opcode ZLOin.
    - T4 ZLowout Gra Rin.
  - br (19):
    - T3 Gra Rout CONin.
    - T4 PCout Yin.
    - T5 Cout ADD ZLOin.
    - T6 ZLowout PCin only if con_ff=1; otherwise no signals asserted.
  - jr (20): T3 Gra Rout PCin.
  - in (22): T3 InPortout Gra Rin.
  - out (23): T3 Gra Rout OutPortin.
  - mfhi (24): T3 HIout Gra Rin.
  - mflo (25): T3 LOout Gra Rin.
  - nop (26), 21, 28..31: T3 with no signals asserted.
  - halt (27): T3 with no signals asserted, then go to HALT.
- Sequencing:
  - The step after an instruction's last step is T0.
  - If stop=1 during the last step, the next state is HALT instead of T0.
  - HALT: all outputs 0, run=0. HALT is left only through clr.
  - stop asserted mid-instruction has no effect until that instruction's last step.
- Reset mid-instruction aborts immediately. The next step is T0 and no partial Write or Rin occurs after clr falls.
- Instruction length in cycles:
  - R-type/immediate/ldi 6
  - ld/st 8
  - mul/div 7
  - br 7
  - neg/not 5
  - single-step ops 4

Test Plan:
- Reset then ir=add(opcode 3): T0 PCout=MARin=IncPC=ZLOin=1, operation=3; T4 Grc=Rout=ZLOin=1, operation=3; T5 Gra=Rin=1; cycle 6 back at T0.
- ld (opcode 0): T3 BAout=1, T5 MARin=1, T6 Read=MDRin=1, T7 MDRout=Rin=1; Write stays 0 throughout; 8 cycles total.
- st (opcode 2): T6 MDRin=1 with Read=0, T7 Write=1 for exactly one cycle.
- br with con_ff=0 then con_ff=1: PCin stays 0 in T6 on the first run, PCin=ZLowout=1 in T6 on the second.
- mul (opcode 15): T4 ZHIin=ZLOin=1, T5 LOin=1, T6 HIin=1; opcode 30 executes as nop in 4 cycles.
- halt (opcode 27): run drops to 0 after T3 and outputs stay 0 for 10 cycles. clr pulsed low during T6 of an ld: outputs go to 0 asynchronously, and fetch restarts at T0 after release.

Source files
------------

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired Moore control unit for the CPU datapath.
// Each instruction walks through fetch steps T0-T2 and opcode-dependent
// execute steps T3-T7; HALT is a terminal state left only through clr.
module control_sequencer #(
  parameter logic [4:0] ADD_OP = 5'd3,
  parameter int         STEP_W = 3
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] ir,
  input  logic        con_ff,
  input  logic        stop,
  // bus source selects
  output logic        PCout,
  output logic        ZHighout,
  output logic        ZLowout,
  output logic        HIout,
  output logic        LOout,
  output logic        InPortout,
  output logic        Cout,
  output logic        MDRout,
  // register load enables
  output logic        MARin,
  output logic        PCin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        HIin,
  output logic        LOin,
  output logic        ZHIin,
  output logic        ZLOin,
  output logic        CONin,
  output logic        OutPortin,
  // ALU mode and memory controls
  output logic        IncPC,
  output logic        Read,
  output logic        Write,
  // register-file field selects and GPR controls
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic [4:0]  operation,
  output logic        run
);

  // Step encoding: T0..T7 occupy the low STEP_W bits, HALT sits above them.
  typedef enum logic [3:0] {
    S_T0   = 4'd0,
    S_T1   = 4'd1,
    S_T2   = 4'd2,
    S_T3   = 4'd3,
    S_T4   = 4'd4,
    S_T5   = 4'd5,
    S_T6   = 4'd6,
    S_T7   = 4'd7,
    S_HALT = 4'd8
  } state_t;

  // Instruction classes sharing one micro-sequence.
  typedef enum logic [3:0] {
    C_RTYPE,
    C_IMM,
    C_LD,
    C_LDI,
    C_ST,
    C_MULDIV,
    C_NEGNOT,
    C_BR,
    C_JR,
    C_IN,
    C_OUT,
    C_MFHI,
    C_MFLO,
    C_HALT,
    C_NOP
  } op_class_t;

  // All control outputs bundled so they can be cleared in one place.
  typedef struct packed {
    logic       pc_out;
    logic       zhigh_out;
    logic       zlow_out;
    logic       hi_out;
    logic       lo_out;
    logic       inport_out;
    logic       c_out;
    logic       mdr_out;
    logic       mar_in;
    logic       pc_in;
    logic       mdr_in;
    logic       ir_in;
    logic       y_in;
    logic       hi_in;
    logic       lo_in;
    logic       zhi_in;
    logic       zlo_in;
    logic       con_in;
    logic       outport_in;
    logic       inc_pc;
    logic       mem_read;
    logic       mem_write;
    logic       gra;
    logic       grb;
    logic       grc;
    logic       r_in;
    logic       r_out;
    logic       ba_out;
    logic [4:0] alu_op;
  } ctrl_t;

  state_t              r_state;
  state_t              w_state_next;
  op_class_t           w_class;
  logic [4:0]          w_opcode;
  logic [STEP_W-1:0]   w_step;
  logic [STEP_W-1:0]   w_last_step;
  ctrl_t               w_ctrl;
  ctrl_t               w_ctrl_out;
  logic                w_unused_ir;

  assign w_opcode    = ir[31:27];
  assign w_step      = r_state[STEP_W-1:0];
  // Only the opcode field steers sequencing; register fields go to the datapath.
  assign w_unused_ir = ^ir[26:0];

  // Classify the opcode into its micro-sequence family.
  always_comb begin
    w_class = C_NOP;
    case (w_opcode)
      5'd0:                                          w_class = C_LD;
      5'd1:                                          w_class = C_LDI;
      5'd2:                                          w_class = C_ST;
      5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9,
      5'd10, 5'd11:                                  w_class = C_RTYPE;
      5'd12, 5'd13, 5'd14:                           w_class = C_IMM;
      5'd15, 5'd16:                                  w_class = C_MULDIV;
      5'd17, 5'd18:                                  w_class = C_NEGNOT;
      5'd19:                                         w_class = C_BR;
      5'd20:                                         w_class = C_JR;
      5'd22:                                         w_class = C_IN;
      5'd23:                                         w_class = C_OUT;
      5'd24:                                         w_class = C_MFHI;
      5'd25:                                         w_class = C_MFLO;
      5'd27:                                         w_class = C_HALT;
      default:                                       w_class = C_NOP;
    endcase
  end

  // Final execute step of each family; never below T3, so garbage in ir during fetch is harmless.
  always_comb begin
    w_last_step = STEP_W'(3);
    case (w_class)
      C_RTYPE, C_IMM, C_LDI: w_last_step = STEP_W'(5);
      C_LD, C_ST:            w_last_step = STEP_W'(7);
      C_MULDIV, C_BR:        w_last_step = STEP_W'(6);
      C_NEGNOT:              w_last_step = STEP_W'(4);
      default:               w_last_step = STEP_W'(3);
    endcase
  end

  // Next step: advance, wrap to T0 after the last step, or divert into HALT.
  always_comb begin
    w_state_next = r_state;
    if (r_state == S_HALT) begin
      w_state_next = S_HALT;
    end else if (w_step == w_last_step) begin
      w_state_next = (stop || (w_class == C_HALT)) ? S_HALT : S_T0;
    end else begin
      w_state_next = state_t'(r_state + 4'd1);
    end
  end

  // Step register; clr aborts any instruction and restarts fetch.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state <= S_T0;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Moore decode of step and opcode into control signals.
  always_comb begin
    w_ctrl = '0;
    case (r_state)
      S_T0: begin
        w_ctrl.pc_out = 1'b1;
        w_ctrl.mar_in = 1'b1;
        w_ctrl.inc_pc = 1'b1;
        w_ctrl.zlo_in = 1'b1;
        w_ctrl.alu_op = ADD_OP;
      end
      S_T1: begin
        w_ctrl.zlow_out = 1'b1;
        w_ctrl.pc_in    = 1'b1;
        w_ctrl.mem_read = 1'b1;
        w_ctrl.mdr_in   = 1'b1;
      end
      S_T2: begin
        w_ctrl.mdr_out = 1'b1;
        w_ctrl.ir_in   = 1'b1;
      end
      S_HALT: begin
        w_ctrl = '0;
      end
      default: begin
        case (w_class)
          C_RTYPE, C_IMM: begin
            case (r_state)
              S_T3: begin
                w_ctrl.grb   = 1'b1;
                w_ctrl.r_out = 1'b1;
                w_ctrl.y_in  = 1'b1;
              end
              S_T4: begin
                // Immediate forms take operand B from the C sign-extend path.
                w_ctrl.grc    = (w_class == C_RTYPE);
                w_ctrl.r_out  = (w_class == C_RTYPE);
                w_ctrl.c_out  = (w_class == C_IMM);
                w_ctrl.alu_op = w_opcode;
                w_ctrl.zlo_in = 1'b1;
              end
              S_T5: begin
                w_ctrl.zlow_out = 1'b1;
                w_ctrl.gra      = 1'b1;
                w_ctrl.r_in     = 1'b1;
              end
              default: w_ctrl = '0;
            endcase
          end
          C_LD, C_LDI, C_ST: begin
            case (r_state)
              S_T3: begin
                w_ctrl.grb    = 1'b1;
                w_ctrl.ba_out = 1'b1;
                w_ctrl.y_in   = 1'b1;
              end
              S_T4: begin
                w_ctrl.c_out  = 1'b1;
                w_ctrl.alu_op = ADD_OP;
                w_ctrl.zlo_in = 1'b1;
              end
              S_T5: begin
                // ldi writes the effective address itself back to Ra.
                w_ctrl.zlow_out = 1'b1;
                w_ctrl.mar_in   = (w_class != C_LDI);
                w_ctrl.gra      = (w_class == C_LDI);
                w_ctrl.r_in     = (w_class == C_LDI);
              end
              S_T6: begin
                // st loads MDR from the bus (Read low), ld loads it from memory.
                w_ctrl.mdr_in   = 1'b1;
                w_ctrl.mem_read = (w_class == C_LD);
                w_ctrl.gra      = (w_class == C_ST);
                w_ctrl.r_out    = (w_class == C_ST);
              end
              S_T7: begin
                w_ctrl.mdr_out   = (w_class == C_LD);
                w_ctrl.gra       = (w_class == C_LD);
                w_ctrl.r_in      = (w_class == C_LD);
                w_ctrl.mem_write = (w_class == C_ST);
              end
              default: w_ctrl = '0;
            endcase
          end
          C_MULDIV: begin
            case (r_state)
              S_T3: begin
                w_ctrl.gra   = 1'b1;
                w_ctrl.r_out = 1'b1;
                w_ctrl.y_in  = 1'b1;
              end
              S_T4: begin
                w_ctrl.grb    = 1'b1;
                w_ctrl.r_out  = 1'b1;
                w_ctrl.alu_op = w_opcode;
                w_ctrl.zhi_in = 1'b1;
                w_ctrl.zlo_in = 1'b1;
              end
              S_T5: begin
                w_ctrl.zlow_out = 1'b1;
                w_ctrl.lo_in    = 1'b1;
              end
              S_T6: begin
                w_ctrl.zhigh_out = 1'b1;
                w_ctrl.hi_in     = 1'b1;
              end
              default: w_ctrl = '0;
            endcase
          end
          C_NEGNOT: begin
            case (r_state)
              S_T3: begin
                w_ctrl.grb    = 1'b1;
                w_ctrl.r_out  = 1'b1;
                w_ctrl.alu_op = w_opcode;
                w_ctrl.zlo_in = 1'b1;
              end
              S_T4: begin
                w_ctrl.zlow_out = 1'b1;
                w_ctrl.gra      = 1'b1;
                w_ctrl.r_in     = 1'b1;
              end
              default: w_ctrl = '0;
            endcase
          end
          C_BR: begin
            case (r_state)
              S_T3: begin
                w_ctrl.gra    = 1'b1;
                w_ctrl.r_out  = 1'b1;
                w_ctrl.con_in = 1'b1;
              end
              S_T4: begin
                w_ctrl.pc_out = 1'b1;
                w_ctrl.y_in   = 1'b1;
              end
              S_T5: begin
                w_ctrl.c_out  = 1'b1;
                w_ctrl.alu_op = ADD_OP;
                w_ctrl.zlo_in = 1'b1;
              end
              S_T6: begin
                // Branch target is committed only when the condition held.
                w_ctrl.zlow_out = con_ff;
                w_ctrl.pc_in    = con_ff;
              end
              default: w_ctrl = '0;
            endcase
          end
          C_JR: begin
            if (r_state == S_T3) begin
              w_ctrl.gra   = 1'b1;
              w_ctrl.r_out = 1'b1;
              w_ctrl.pc_in = 1'b1;
            end
          end
          C_IN: begin
            if (r_state == S_T3) begin
              w_ctrl.inport_out = 1'b1;
              w_ctrl.gra        = 1'b1;
              w_ctrl.r_in       = 1'b1;
            end
          end
          C_OUT: begin
            if (r_state == S_T3) begin
              w_ctrl.gra        = 1'b1;
              w_ctrl.r_out      = 1'b1;
              w_ctrl.outport_in = 1'b1;
            end
          end
          C_MFHI: begin
            if (r_state == S_T3) begin
              w_ctrl.hi_out = 1'b1;
              w_ctrl.gra    = 1'b1;
              w_ctrl.r_in   = 1'b1;
            end
          end
          C_MFLO: begin
            if (r_state == S_T3) begin
              w_ctrl.lo_out = 1'b1;
              w_ctrl.gra    = 1'b1;
              w_ctrl.r_in   = 1'b1;
            end
          end
          default: w_ctrl = '0;
        endcase
      end
    endcase
  end

  // clr forces every control low immediately, without waiting for a clock edge.
  assign w_ctrl_out = clr ? w_ctrl : '0;

  assign PCout     = w_ctrl_out.pc_out;
  assign ZHighout  = w_ctrl_out.zhigh_out;
  assign ZLowout   = w_ctrl_out.zlow_out;
  assign HIout     = w_ctrl_out.hi_out;
  assign LOout     = w_ctrl_out.lo_out;
  assign InPortout = w_ctrl_out.inport_out;
  assign Cout      = w_ctrl_out.c_out;
  assign MDRout    = w_ctrl_out.mdr_out;
  assign MARin     = w_ctrl_out.mar_in;
  assign PCin      = w_ctrl_out.pc_in;
  assign MDRin     = w_ctrl_out.mdr_in;
  assign IRin      = w_ctrl_out.ir_in;
  assign Yin       = w_ctrl_out.y_in;
  assign HIin      = w_ctrl_out.hi_in;
  assign LOin      = w_ctrl_out.lo_in;
  assign ZHIin     = w_ctrl_out.zhi_in;
  assign ZLOin     = w_ctrl_out.zlo_in;
  assign CONin     = w_ctrl_out.con_in;
  assign OutPortin = w_ctrl_out.outport_in;
  assign IncPC     = w_ctrl_out.inc_pc;
  assign Read      = w_ctrl_out.mem_read;
  assign Write     = w_ctrl_out.mem_write;
  assign Gra       = w_ctrl_out.gra;
  assign Grb       = w_ctrl_out.grb;
  assign Grc       = w_ctrl_out.grc;
  assign Rin       = w_ctrl_out.r_in;
  assign Rout      = w_ctrl_out.r_out;
  assign BAout     = w_ctrl_out.ba_out;
  assign operation = w_ctrl_out.alu_op;
  assign run       = (r_state != S_HALT);

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: randomized self-checking bench. The reference model is
// a table of micro-step strings (signal names per step) plus an instruction
// length table, parsed into expected control vectors each cycle.
module tb_control_sequencer;

  localparam logic [4:0] ADD_OP = 5'd3;

  logic        clk;
  logic        clr;
  logic [31:0] ir;
  logic        con_ff;
  logic        stop;
  logic PCout, ZHighout, ZLowout, HIout, LOout, InPortout, Cout, MDRout;
  logic MARin, PCin, MDRin, IRin, Yin, HIin, LOin, ZHIin, ZLOin, CONin, OutPortin;
  logic IncPC, Read, Write, Gra, Grb, Grc, Rin, Rout, BAout;
  logic [4:0]  operation;
  logic        run;

  int n_checks = 0;
  int n_err    = 0;

  control_sequencer #(.ADD_OP(ADD_OP), .STEP_W(3)) dut (
    .clk(clk), .clr(clr), .ir(ir), .con_ff(con_ff), .stop(stop),
    .PCout(PCout), .ZHighout(ZHighout), .ZLowout(ZLowout), .HIout(HIout),
    .LOout(LOout), .InPortout(InPortout), .Cout(Cout), .MDRout(MDRout),
    .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
    .HIin(HIin), .LOin(LOin), .ZHIin(ZHIin), .ZLOin(ZLOin), .CONin(CONin),
    .OutPortin(OutPortin), .IncPC(IncPC), .Read(Read), .Write(Write),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .operation(operation), .run(run)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Signal names; position i corresponds to bit i of act_vec.
  string names [28] = '{"PCout", "ZHighout", "ZLowout", "HIout", "LOout",
                        "InPortout", "Cout", "MDRout", "MARin", "PCin", "MDRin",
                        "IRin", "Yin", "HIin", "LOin", "ZHIin", "ZLOin", "CONin",
                        "OutPortin", "IncPC", "Read", "Write", "Gra", "Grb",
                        "Grc", "Rin", "Rout", "BAout"};

  logic [27:0] act_vec;
  assign act_vec = {BAout, Rout, Rin, Grc, Grb, Gra, Write, Read, IncPC,
                    OutPortin, CONin, ZLOin, ZHIin, LOin, HIin, Yin, IRin,
                    MDRin, PCin, MARin, MDRout, Cout, InPortout, LOout, HIout,
                    ZLowout, ZHighout, PCout};

  // Instruction length in cycles, straight from the per-class length list.
  function automatic int instr_len(input int op);
    if (op >= 3 && op <= 14) return 6;
    if (op == 1)             return 6;
    if (op == 0 || op == 2)  return 8;
    if (op == 15 || op == 16) return 7;
    if (op == 19)            return 7;
    if (op == 17 || op == 18) return 5;
    return 4;
  endfunction

  // Micro-program text for one step. "ADD" = ADD_OP on operation, "OP" = opcode.
  function automatic string micro(input int op, input int step, input bit con);
    string t[$];
    if (step == 0) return "PCout MARin IncPC ZLOin ADD";
    if (step == 1) return "ZLowout PCin Read MDRin";
    if (step == 2) return "MDRout IRin";
    if (op >= 3 && op <= 11)
      t = '{"Grb Rout Yin", "Grc Rout OP ZLOin", "ZLowout Gra Rin"};
    else if (op >= 12 && op <= 14)
      t = '{"Grb Rout Yin", "Cout OP ZLOin", "ZLowout Gra Rin"};
    else if (op == 0)
      t = '{"Grb BAout Yin", "Cout ADD ZLOin", "ZLowout MARin", "Read MDRin", "MDRout Gra Rin"};
    else if (op == 1)
      t = '{"Grb BAout Yin", "Cout ADD ZLOin", "ZLowout Gra Rin"};
    else if (op == 2)
      t = '{"Grb BAout Yin", "Cout ADD ZLOin", "ZLowout MARin", "Gra Rout MDRin", "Write"};
    else if (op == 15 || op == 16)
      t = '{"Gra Rout Yin", "Grb Rout OP ZHIin ZLOin", "ZLowout LOin", "ZHighout HIin"};
    else if (op == 17 || op == 18)
      t = '{"Grb Rout OP ZLOin", "ZLowout Gra Rin"};
    else if (op == 19)
      t = '{"Gra Rout CONin", "PCout Yin", "Cout ADD ZLOin", con ? "ZLowout PCin" : ""};
    else if (op == 20) t = '{"Gra Rout PCin"};
    else if (op == 22) t = '{"InPortout Gra Rin"};
    else if (op == 23) t = '{"Gra Rout OutPortin"};
    else if (op == 24) t = '{"HIout Gra Rin"};
    else if (op == 25) t = '{"LOout Gra Rin"};
    else t = '{""};
    if (step - 3 < t.size()) return t[step - 3];
    return "";
  endfunction

  // Parse a micro-step string into {operation, control vector}.
  function automatic logic [32:0] parse(input string s, input int op);
    logic [27:0] vec;
    logic [4:0]  oper;
    string tok;
    vec = '0; oper = '0; tok = "";
    for (int i = 0; i <= s.len(); i++) begin
      if (i == s.len() || s.getc(i) == " ") begin
        if (tok == "ADD") oper = ADD_OP;
        else if (tok == "OP") oper = op[4:0];
        else for (int j = 0; j < 28; j++) if (names[j] == tok) vec[j] = 1'b1;
        tok = "";
      end else begin
        tok = {tok, s.substr(i, i)};
      end
    end
    return {oper, vec};
  endfunction

  // Runs one instruction (or its first nsteps steps), checking every step.
  task automatic exec_instr(input int op, input bit con, input bit stop_end,
                            input int nsteps, output int write_cnt, output bit halted);
    int len;
    logic [33:0] exp_w, act_w;
    len = instr_len(op);
    ir = {op[4:0], 27'($urandom)};
    con_ff = con;
    write_cnt = 0;
    for (int s = 0; s < nsteps && s < len; s++) begin
      // stop is ignored except on the last step
      stop = (s == len - 1) ? stop_end : 1'($urandom_range(0, 1));
      #1;
      exp_w = {1'b1, parse(micro(op, s, con), op)};
      act_w = {run, operation, act_vec};
      n_checks++;
      if (act_w !== exp_w) begin
        n_err++;
        $display("FAIL step op=%0d T%0d con=%0b got=%h want=%h", op, s, con, act_w, exp_w);
      end
      if (Write) write_cnt++;
      @(posedge clk); #1;
    end
    stop = 1'b0;
    halted = (nsteps >= len) && (stop_end || op == 27);
    $display("instr op=%0d con=%0b stop=%0b steps=%0d writes=%0d halted=%0b",
             op, con, stop_end, (nsteps < len) ? nsteps : len, write_cnt, halted);
  endtask

  task automatic check_halted(input int ncycles);
    for (int i = 0; i < ncycles; i++) begin
      #1;
      n_checks++;
      if ({run, operation, act_vec} !== 34'd0) begin
        n_err++;
        $display("FAIL halt_idle cycle=%0d got=%h want=0", i, {run, operation, act_vec});
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    clr = 1'b0; stop = 1'b0; con_ff = 1'b0; ir = '0;
    #1;
    n_checks++;
    if ({run, operation, act_vec} !== {1'b1, 33'd0}) begin
      n_err++;
      $display("FAIL reset_async got=%h want=%h", {run, operation, act_vec}, {1'b1, 33'd0});
    end
    repeat (2) @(posedge clk);
    #2;
    n_checks++;
    if ({run, operation, act_vec} !== {1'b1, 33'd0}) begin
      n_err++;
      $display("FAIL reset_hold got=%h want=%h", {run, operation, act_vec}, {1'b1, 33'd0});
    end
    @(posedge clk); #1;
    clr = 1'b1;
    $display("reset released");
  endtask

  task automatic test_add();
    int w; bit h;
    exec_instr(3, 1'($urandom), 1'b0, 99, w, h);
    exec_instr(12, 1'($urandom), 1'b0, 99, w, h);  // addi: next fetch starts at T0
  endtask

  task automatic test_ld();
    int w; bit h;
    exec_instr(0, 1'($urandom), 1'b0, 99, w, h);
    n_checks++;
    if (w !== 0) begin n_err++; $display("FAIL ld_no_write got=%0d want=0", w); end
    exec_instr(1, 1'($urandom), 1'b0, 99, w, h);
  endtask

  task automatic test_st();
    int w; bit h;
    exec_instr(2, 1'($urandom), 1'b0, 99, w, h);
    n_checks++;
    if (w !== 1) begin n_err++; $display("FAIL st_write_once got=%0d want=1", w); end
  endtask

  task automatic test_br();
    int w; bit h;
    exec_instr(19, 1'b0, 1'b0, 99, w, h);
    exec_instr(19, 1'b1, 1'b0, 99, w, h);
  endtask

  task automatic test_mul_nop();
    int w; bit h;
    exec_instr(15, 1'($urandom), 1'b0, 99, w, h);
    exec_instr(16, 1'($urandom), 1'b0, 99, w, h);
    exec_instr(30, 1'($urandom), 1'b0, 99, w, h);
    exec_instr(17, 1'($urandom), 1'b0, 99, w, h);
  endtask

  task automatic test_halt();
    int w; bit h;
    exec_instr(27, 1'($urandom), 1'b0, 99, w, h);
    n_checks++;
    if (h !== 1'b1) begin n_err++; $display("FAIL halt_model got=%0b want=1", h); end
    check_halted(10);
    test_reset();
  endtask

  task automatic test_clr_abort();
    int w; bit h;
    exec_instr(0, 1'b0, 1'b0, 6, w, h);   // stop in T6 of ld
    #1;
    n_checks++;
    if ({run, operation, act_vec} !== {1'b1, parse("Read MDRin", 0)}) begin
      n_err++;
      $display("FAIL ld_T6 got=%h want=%h", {run, operation, act_vec}, {1'b1, parse("Read MDRin", 0)});
    end
    #1; clr = 1'b0;
    #1;
    n_checks++;
    if ({run, operation, act_vec} !== {1'b1, 33'd0}) begin
      n_err++;
      $display("FAIL clr_abort_async got=%h want=%h", {run, operation, act_vec}, {1'b1, 33'd0});
    end
    @(posedge clk); #2;
    n_checks++;
    if ({Write, Rin} !== 2'b00) begin
      n_err++;
      $display("FAIL clr_abort_hold got=%b want=00", {Write, Rin});
    end
    @(posedge clk); #1; clr = 1'b1;
    exec_instr(3, 1'b0, 1'b0, 99, w, h);  // fetch restarts at T0
  endtask

  task automatic test_stop();
    int w; bit h;
    exec_instr(7, 1'b0, 1'b1, 99, w, h);
    check_halted(4);
    test_reset();
    exec_instr(0, 1'b1, 1'b1, 99, w, h);
    check_halted(3);
    test_reset();
  endtask

  task automatic test_back_to_back();
    int w; bit h; int op;
    for (int k = 0; k < 40; k++) begin
      op = int'($urandom_range(0, 31));
      if (op == 27) op = 26;
      exec_instr(op, 1'($urandom), 1'b0, 99, w, h);
      n_checks++;
      if (h !== 1'b0) begin n_err++; $display("FAIL b2b_no_halt op=%0d got=%0b want=0", op, h); end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_ld();
    test_st();
    test_br();
    test_mul_nop();
    test_halt();
    test_clr_abort();
    test_stop();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
